// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types for the HUB-75 line receiver
package hub75_pkg;

  typedef logic [5:0] Rgb6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/hub75_input_sync.sv
// rtl/hub75_input_sync.sv - two-flop synchronizer with optional registered rise detect
module hub75_input_sync #(
  parameter int width = 1,
  parameter bit rise  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Data paths take the third stage so they line up with the registered edge pulse.
  if (rise) begin : g_rise
    logic [width-1:0] edge_d, edge_q;

    always_comb begin
      edge_d = sync2_q & ~sync3_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) edge_q <= '0;
      else       edge_q <= edge_d;
    end

    assign dout = edge_q;
  end else begin : g_data
    assign dout = sync3_q;
  end

endmodule

// File: rtl/hub75_receiver.sv
// rtl/hub75_receiver.sv - HUB-75 panel input to column-ordered pixel stream
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int panel_width = 64,
  parameter int row_bits    = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           hub_clk,
  input  logic                           hub_lat,
  input  logic [row_bits-1:0]            hub_addr,
  input  logic [5:0]                     hub_rgb,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [row_bits-1:0]            pix_row,
  output logic [$clog2(panel_width)-1:0] pix_col,
  output logic [5:0]                     pix_rgb,
  output logic                           overrun,
  output logic                           line_err
);

  localparam int col_bits = $clog2(panel_width);
  localparam int cnt_bits = $clog2(panel_width + 2);

  logic [1:0]            edge_s;
  logic [row_bits+5:0]   data_s;
  logic                  clk_rise, lat_rise;
  logic [row_bits-1:0]   addr_s;
  Rgb6                   rgb_s;

  hub75_input_sync #(.width(2), .rise(1'b1)) u_edge_sync (
    .clock (clock),
    .reset (reset),
    .din   ({hub_lat, hub_clk}),
    .dout  (edge_s)
  );

  hub75_input_sync #(.width(row_bits + 6), .rise(1'b0)) u_data_sync (
    .clock (clock),
    .reset (reset),
    .din   ({hub_addr, hub_rgb}),
    .dout  (data_s)
  );

  assign clk_rise = edge_s[0];
  assign lat_rise = edge_s[1];
  assign addr_s   = data_s[row_bits+5:6];
  assign rgb_s    = data_s[5:0];

  state_e              state_d, state_q;
  Rgb6                 shift_d [panel_width];
  Rgb6                 shift_q [panel_width];
  Rgb6                 line_d  [panel_width];
  Rgb6                 line_q  [panel_width];
  logic [cnt_bits-1:0] cnt_d, cnt_q, cnt_inc;
  logic [row_bits-1:0] row_d, row_q;
  logic [col_bits-1:0] col_d, col_q, col_nxt;
  Rgb6                 rgb_d, rgb_q;
  logic                overrun_d, overrun_q;
  logic                line_err_d, line_err_q;

  // Shift array index c always holds the word destined for column c.
  always_comb begin
    shift_d = shift_q;
    if (clk_rise) begin
      shift_d[0] = rgb_s;
      for (int i = 1; i < panel_width; i++) shift_d[i] = shift_q[i-1];
    end
    cnt_inc = cnt_q;
    if (clk_rise && cnt_q != cnt_bits'(panel_width + 1)) cnt_inc = cnt_q + cnt_bits'(1);
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    cnt_d      = cnt_inc;
    row_d      = row_q;
    col_d      = col_q;
    rgb_d      = rgb_q;
    overrun_d  = 1'b0;
    line_err_d = 1'b0;
    col_nxt    = col_q + col_bits'(1);

    if (state_q == SEND && pix_ready) begin
      col_d = col_nxt;
      rgb_d = line_q[col_nxt];
      if (col_q == col_bits'(panel_width - 1)) state_d = IDLE;
    end

    // The latch sees the post-shift array and count, so a coincident shift is included.
    if (lat_rise) begin
      cnt_d      = '0;
      line_err_d = (cnt_inc != cnt_bits'(panel_width));
      if (state_q == IDLE) begin
        line_d  = shift_d;
        row_d   = addr_s;
        col_d   = '0;
        rgb_d   = shift_d[0];
        state_d = SEND;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rgb_q      <= '0;
      overrun_q  <= 1'b0;
      line_err_q <= 1'b0;
      for (int i = 0; i < panel_width; i++) begin
        shift_q[i] <= '0;
        line_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rgb_q      <= rgb_d;
      overrun_q  <= overrun_d;
      line_err_q <= line_err_d;
      shift_q    <= shift_d;
      line_q     <= line_d;
    end
  end

  assign pix_valid = (state_q == SEND);
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_rgb   = rgb_q;
  assign overrun   = overrun_q;
  assign line_err  = line_err_q;

endmodule

// File: doc/hub75_receiver.md
HUB75_RECEIVER -- requirements
Module: hub75_receiver

Interface
REQ-001 The block SHALL have parameter panel_width, default 64, meaning columns shifted per line (power of two, 8..256).
REQ-002 The block SHALL have parameter row_bits, default 5, meaning width of the HUB-75 row address.
REQ-003 The block SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port hub_clk  input  1  HUB-75 shift clock, asynchronous to clock.
REQ-006 The block SHALL have port hub_lat  input  1  HUB-75 latch strobe, asynchronous.
REQ-007 The block SHALL have port hub_addr  input  row_bits  HUB-75 row address, asynchronous.
REQ-008 The block SHALL have port hub_rgb  input  6  {R1,G1,B1,R2,G2,B2}, asynchronous.
REQ-009 The block SHALL have port pix_valid  output  1  pixel word available.
REQ-010 The block SHALL have port pix_ready  input  1  downstream accepts the pixel word.
REQ-011 The block SHALL have port pix_row  output  row_bits  row address captured at latch.
REQ-012 The block SHALL have port pix_col  output  $clog2(panel_width)  column index of the current word.
REQ-013 The block SHALL have port pix_rgb  output  6  pixel data for pix_col.
REQ-014 The block SHALL have port overrun  output  1  one-cycle pulse: latch edge dropped because the block was busy.
REQ-015 The block SHALL have port line_err  output  1  one-cycle pulse: shift count since the previous latch differed from panel_width.

Function
REQ-016 All hub_* inputs SHALL pass through two synchronizer flops; edges SHALL be detected on the second stage against a third delay flop.
REQ-017 On each synchronized hub_clk rising edge, the block SHALL shift the synchronized hub_rgb into the shift array and increment a shift counter that saturates at panel_width+1.
REQ-018 After exactly panel_width shifts, the k-th shifted word (k from 0) SHALL map to column panel_width-1-k.
REQ-019 The FSM SHALL have states IDLE and SEND.
REQ-020 In IDLE, a synchronized hub_lat rising edge SHALL copy the shift array into the line buffer, capture hub_addr into pix_row, set pix_col to 0, and enter SEND.
REQ-021 The same latch edge SHALL pulse line_err if the shift count is not equal to panel_width, and SHALL clear the shift counter.
REQ-022 pix_valid SHALL be 1 exactly while in SEND; pix_row, pix_col and pix_rgb SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-023 On pix_valid and pix_ready both high, pix_col SHALL increment; on acceptance at pix_col=panel_width-1, the FSM SHALL return to IDLE with pix_valid=0 on the next cycle.
REQ-024 A latch edge in SEND SHALL be ignored, pulse overrun for one cycle, leave the line buffer unchanged, and still clear the shift counter.
REQ-025 When a hub_clk edge and a hub_lat edge are detected in the same cycle, the shift SHALL take effect first, and the latch SHALL capture data that includes the new word.
REQ-026 Latency: pix_valid SHALL rise at the 4th rising clock edge, counting as the 1st the edge at which hub_lat is first sampled 1.
REQ-027 Shifting SHALL continue in SEND without corrupting the line buffer, which is double-buffered against the shift array.
REQ-028 Throughput SHALL be one pixel per cycle while pix_ready=1.

Reset
REQ-029 Reset SHALL force state IDLE, pix_valid=0, pix_row=0, pix_col=0, pix_rgb=0, overrun=0, line_err=0, all synchronizer flops 0, shift counter 0, and shift array and line buffer 0.
REQ-030 Reset asserted in SEND SHALL abandon the line immediately, with no further pix_valid until a new latch edge.
REQ-031 An input that is high at reset release SHALL register as one rising edge.

Structure
REQ-032 Shared package hub75_pkg SHALL hold typedef Rgb6 (logic[5:0]) and the FSM state enum.
REQ-033 Sub-module hub75_input_sync SHALL hold the two-flop synchronizer plus the rise-edge detector, parameterized by width, and SHALL be instantiated for the clk/lat (rise) and addr/rgb (data) paths.

Verification
REQ-034 Reset, 64 hub_clk pulses with rgb=col index mod 64 reversed, then a latch with addr=5 -> 64 words, col 0..63 in order, row=5, rgb matches, line_err=0.
REQ-035 pix_ready toggled 1,0,0,1 during SEND -> no word lost or duplicated, outputs stable while ready=0.
REQ-036 63 shifts then a latch -> line_err pulses once, and the line is still emitted.
REQ-037 A second latch while pix_ready=0 in SEND -> overrun pulses once, and the first line's data is emitted unchanged.
REQ-038 hub_clk and hub_lat rising together -> the final shifted word appears at col 0.
REQ-039 Reset asserted mid-line at col=20 -> pix_valid=0 on the next cycle, and no output until the next latch.
